// File: rtl/draw_bullet_if.sv
// Video timing bundle passed between pipeline stages: counters, strobes
// and the pixel colour travelling with them.
interface draw_bullet_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bullet.sv
// Bullet overlay stage: launches a bullet from gun_x on a fire edge, moves it
// upward once per frame, detects overlap with target-coloured pixels and
// shows a short explosion before returning to idle. Timing passes through
// with one cycle of latency.
module draw_bullet #(
    parameter int          BULLET_W     = 4,
    parameter int          BULLET_H     = 8,
    parameter int          START_Y      = 560,
    parameter int          SPEED        = 4,
    parameter int          BOOM_FRAMES  = 8,
    parameter logic [11:0] BULLET_COLOR = 12'hFF0,
    parameter logic [11:0] BOOM_COLOR   = 12'hF00,
    parameter logic [11:0] TARGET_COLOR = 12'h0F0
) (
    input  logic                 pclk,
    input  logic                 rst,
    draw_bullet_if.slave         vga_in,
    draw_bullet_if.master        vga_out,
    input  logic                 fire_in,
    input  logic [10:0]          gun_x,
    output logic                 busy,
    output logic                 hit_pulse
);

    localparam int          CNT_W   = (BOOM_FRAMES > 2) ? $clog2(BOOM_FRAMES) : 1;
    localparam logic [10:0] X_MAX   = 11'(800 - BULLET_W);
    localparam logic [10:0] Y_START = 11'(START_Y);
    localparam logic [10:0] Y_STEP  = 11'(SPEED);

    typedef enum logic [1:0] {IDLE, FLY, BOOM} state_t;

    state_t           state;
    logic [10:0]      x;
    logic [10:0]      y;
    logic [CNT_W-1:0] boom_cnt;
    logic             hit_flag;
    logic             vblnk_prev;
    logic             fire_prev;
    logic             fire_armed;

    logic             frame_tick;
    logic             launch;
    logic             blank;
    logic             in_box;
    logic             draw_px;
    logic [11:0]      hc_ext;
    logic [11:0]      vc_ext;

    // Keep the bullet fully on the 800-pixel-wide screen.
    function automatic logic [10:0] clamp_x(input logic [10:0] gx);
        return (gx > X_MAX) ? X_MAX : gx;
    endfunction

    // Frame tick, launch edge and bullet-rectangle hit test for the current pixel.
    always_comb begin
        hc_ext     = {1'b0, vga_in.hcount};
        vc_ext     = {1'b0, vga_in.vcount};
        frame_tick = vga_in.vblnk & ~vblnk_prev;
        launch     = fire_in & ~fire_prev & fire_armed;
        blank      = vga_in.hblnk | vga_in.vblnk;
        in_box     = (hc_ext >= {1'b0, x}) && (hc_ext < ({1'b0, x} + 12'(BULLET_W))) &&
                     (vc_ext >= {1'b0, y}) && (vc_ext < ({1'b0, y} + 12'(BULLET_H)));
        draw_px    = in_box && !blank && (state != IDLE);
    end

    // Edge detectors; fire_armed blocks a launch until fire_in has been seen low,
    // so a level held through reset cannot launch on release.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            fire_prev  <= 1'b0;
            fire_armed <= 1'b0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            fire_prev  <= fire_in;
            fire_armed <= fire_armed | ~fire_in;
        end
    end

    // Bullet state machine: position, sticky hit flag, explosion counter and hit strobe.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            boom_cnt  <= '0;
            hit_flag  <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= FLY;
                        x        <= clamp_x(gun_x);
                        y        <= Y_START;
                        hit_flag <= 1'b0;
                    end
                end
                FLY: begin
                    if (frame_tick) begin
                        if (hit_flag) begin
                            state     <= BOOM;
                            hit_pulse <= 1'b1;
                            boom_cnt  <= CNT_W'(BOOM_FRAMES - 1);
                        end else if (y < Y_STEP) begin
                            state <= IDLE;
                        end else begin
                            y <= y - Y_STEP;
                        end
                    end else if (draw_px && (vga_in.rgb == TARGET_COLOR)) begin
                        hit_flag <= 1'b1;
                    end
                end
                BOOM: begin
                    if (frame_tick) begin
                        if (boom_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            boom_cnt <= boom_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // One-cycle timing delay with the composed pixel colour.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= vga_in.hcount;
            vga_out.vcount <= vga_in.vcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.vblnk  <= vga_in.vblnk;
            if (blank) begin
                vga_out.rgb <= 12'h000;
            end else if (draw_px) begin
                vga_out.rgb <= (state == BOOM) ? BOOM_COLOR : BULLET_COLOR;
            end else begin
                vga_out.rgb <= vga_in.rgb;
            end
        end
    end

endmodule

// File: tb/tb_draw_bullet.sv
// Directed bench for draw_bullet: pass-through timing, launch/flight geometry,
// clamping, off-top exit, target hit with explosion, fire edge handling, reset.
`timescale 1ns/1ps
module tb_draw_bullet;

    logic        pclk = 1'b0;
    logic        rst;
    logic        fire_in;
    logic [10:0] gun_x;
    logic        busy;
    logic        hit_pulse;

    int n_vec   = 0;
    int n_err   = 0;
    int hit_cnt = 0;

    draw_bullet_if vga_in ();
    draw_bullet_if vga_out ();

    draw_bullet dut (
        .pclk      (pclk),
        .rst       (rst),
        .vga_in    (vga_in),
        .vga_out   (vga_out),
        .fire_in   (fire_in),
        .gun_x     (gun_x),
        .busy      (busy),
        .hit_pulse (hit_pulse)
    );

    always #12.5 pclk = ~pclk;

    // Count hit strobes away from the active edge.
    always @(negedge pclk) begin
        if (hit_pulse === 1'b1) hit_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present one pixel and advance one clock; outputs then reflect it.
    task automatic pix(input int h, input int v, input logic hb, input logic vb,
                       input logic [11:0] rgb);
        vga_in.hcount = 11'(h);
        vga_in.vcount = 11'(v);
        vga_in.hsync  = 1'b0;
        vga_in.vsync  = 1'b0;
        vga_in.hblnk  = hb;
        vga_in.vblnk  = vb;
        vga_in.rgb    = rgb;
        @(posedge pclk);
        #1;
    endtask

    task automatic probe(input string tag, input int h, input int v,
                         input logic [11:0] rgb, input logic [11:0] exp);
        pix(h, v, 1'b0, 1'b0, rgb);
        check(tag, int'(vga_out.rgb), int'(exp));
    endtask

    // Vertical blank rising edge, then back to a non-vblank blank pixel.
    task automatic tick();
        pix(0, 600, 1'b1, 1'b1, 12'h123);
        pix(0, 0, 1'b1, 1'b0, 12'h123);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] c;
        int y;
        rst     = 1'b1;
        fire_in = 1'b0;
        gun_x   = 11'd0;
        vga_in.hcount = 11'd5;
        vga_in.vcount = 11'd7;
        vga_in.hsync  = 1'b1;
        vga_in.vsync  = 1'b1;
        vga_in.hblnk  = 1'b1;
        vga_in.vblnk  = 1'b1;
        vga_in.rgb    = 12'hABC;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_hcount", int'(vga_out.hcount), 0);
        check("rst_vcount", int'(vga_out.vcount), 0);
        check("rst_hsync",  int'(vga_out.hsync), 0);
        check("rst_vblnk",  int'(vga_out.vblnk), 0);
        check("rst_rgb",    int'(vga_out.rgb), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_hit",    int'(hit_pulse), 0);
        @(negedge pclk);
        rst = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 12'h123);

        // Pass-through with exactly one cycle of delay
        vga_in.hcount = 11'd123;
        vga_in.vcount = 11'd45;
        vga_in.hsync  = 1'b1;
        vga_in.vsync  = 1'b0;
        vga_in.hblnk  = 1'b0;
        vga_in.vblnk  = 1'b0;
        vga_in.rgb    = 12'h123;
        @(posedge pclk);
        #1;
        check("pt_hcount", int'(vga_out.hcount), 123);
        check("pt_vcount", int'(vga_out.vcount), 45);
        check("pt_hsync",  int'(vga_out.hsync), 1);
        check("pt_vsync",  int'(vga_out.vsync), 0);
        check("pt_rgb",    int'(vga_out.rgb), 12'h123);
        vga_in.hcount = 11'd124;
        vga_in.hsync  = 1'b0;
        #2;
        check("pt_hold_hcount", int'(vga_out.hcount), 123);
        check("pt_hold_hsync",  int'(vga_out.hsync), 1);
        @(posedge pclk);
        #1;
        check("pt_next_hcount", int'(vga_out.hcount), 124);
        pix(10, 20, 1'b1, 1'b0, 12'h123);
        check("hblank_rgb", int'(vga_out.rgb), 0);
        check("hblank_out", int'(vga_out.hblnk), 1);
        pix(10, 20, 1'b0, 1'b1, 12'h123);
        check("vblank_rgb", int'(vga_out.rgb), 0);
        check("vblank_out", int'(vga_out.vblnk), 1);
        probe("idle_px0",   0,   0,   12'h123, 12'h123);
        probe("idle_px799", 799, 599, 12'h123, 12'h123);
        check("idle_busy", int'(busy), 0);

        // Launch at column 100 and fly to the top without a target
        gun_x   = 11'd100;
        fire_in = 1'b1;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b0;
        check("fly_busy", int'(busy), 1);
        probe("b_tl",     100, 560, 12'h123, 12'hFF0);
        probe("b_br",     103, 567, 12'h123, 12'hFF0);
        probe("b_right",  104, 560, 12'h123, 12'h123);
        probe("b_left",   99,  560, 12'h123, 12'h123);
        probe("b_below",  100, 568, 12'h123, 12'h123);
        probe("b_above",  100, 559, 12'h123, 12'h123);
        tick();
        probe("f1_tl",    100, 556, 12'h123, 12'hFF0);
        probe("f1_br",    103, 563, 12'h123, 12'hFF0);
        probe("f1_below", 100, 564, 12'h123, 12'h123);
        for (int k = 2; k <= 140; k++) tick();
        check("t140_busy", int'(busy), 1);
        probe("t140_top", 100, 0, 12'h123, 12'hFF0);
        probe("t140_bot", 100, 7, 12'h123, 12'hFF0);
        probe("t140_out", 100, 8, 12'h123, 12'h123);
        tick();
        check("t141_busy", int'(busy), 0);
        probe("t141_gone", 100, 0, 12'h123, 12'h123);
        check("no_hit_cnt", hit_cnt, 0);

        // Clamp to the right edge, then reset mid-flight with fire held
        gun_x   = 11'd1000;
        fire_in = 1'b1;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b0;
        probe("clamp_tl",  796, 560, 12'h123, 12'hFF0);
        probe("clamp_br",  799, 567, 12'h123, 12'hFF0);
        probe("clamp_l",   795, 560, 12'h123, 12'h123);
        probe("clamp_r",   800, 560, 12'h123, 12'h123);
        fire_in = 1'b1;
        rst     = 1'b1;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rgb",  int'(vga_out.rgb), 0);
        @(negedge pclk);
        rst = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        check("held_fire_no_launch", int'(busy), 0);
        tick();
        probe("midrst_gone", 796, 560, 12'h123, 12'h123);
        check("midrst_hit_cnt", hit_cnt, 0);
        fire_in = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b1;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        check("new_edge_launch", int'(busy), 1);
        fire_in = 1'b0;
        do_reset();

        // Launch coinciding with a frame tick, fire held, re-pulse in flight
        gun_x   = 11'd300;
        fire_in = 1'b1;
        pix(0, 600, 1'b1, 1'b1, 12'h123);
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        check("tick_launch_busy", int'(busy), 1);
        probe("tl_bot",   300, 567, 12'h123, 12'hFF0);
        probe("tl_above", 300, 559, 12'h123, 12'h123);
        repeat (3) tick();
        fire_in = 1'b0;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b1;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b0;
        probe("hold_top",   300, 548, 12'h123, 12'hFF0);
        probe("hold_above", 300, 547, 12'h123, 12'h123);
        probe("hold_bot",   300, 555, 12'h123, 12'hFF0);
        probe("hold_below", 300, 556, 12'h123, 12'h123);
        tick();
        probe("repulse_ignored", 300, 544, 12'h123, 12'hFF0);
        do_reset();
        tick();
        check("rst_fly_busy", int'(busy), 0);
        probe("rst_fly_gone", 300, 544, 12'h123, 12'h123);

        // Hit a target block at rows 500-510
        gun_x   = 11'd200;
        fire_in = 1'b1;
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        fire_in = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            y = 560 - 4 * k;
            for (int r = 0; r < 8; r++) begin
                c = ((y + r) >= 500 && (y + r) <= 510) ? 12'h0F0 : 12'h123;
                probe("hit_fly_px", 200, y + r, c, 12'hFF0);
            end
            if (k < 13) tick();
        end
        check("pre_hit_cnt", hit_cnt, 0);
        pix(0, 600, 1'b1, 1'b1, 12'h123);
        check("hit_pulse_hi", int'(hit_pulse), 1);
        check("hit_busy", int'(busy), 1);
        pix(0, 0, 1'b1, 1'b0, 12'h123);
        check("hit_pulse_lo", int'(hit_pulse), 0);
        for (int f = 0; f < 8; f++) begin
            probe("boom_tl", 200, 508, 12'h0F0, 12'hF00);
            probe("boom_br", 203, 515, 12'h0F0, 12'hF00);
            tick();
            check("boom_busy", int'(busy), (f < 7) ? 1 : 0);
        end
        probe("boom_gone", 200, 508, 12'h0F0, 12'h0F0);
        check("hit_cnt_total", hit_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
